// File: rtl/mem_arbiter_nch_if.sv
// Requestor-side and memory-side signals of the N-channel memory arbiter.
// slave = arbiter view, master = environment (requestors + memory) view.
interface mem_arbiter_nch_if #(
    parameter int NCH   = 4,
    parameter int AW    = 22,
    parameter int DW    = 64,
    parameter int OUTST = 4
);
    localparam int OW = $clog2(OUTST) + 1;

    logic [NCH-1:0]    i_rd_req;
    logic [NCH*AW-1:0] i_rd_addr;
    logic [NCH-1:0]    o_rd_addr_ack;
    logic [NCH-1:0]    o_rd_ack;
    logic [DW-1:0]     o_rd_data;
    logic [NCH-1:0]    i_wr_req;
    logic [NCH*AW-1:0] i_wr_addr;
    logic [NCH*DW-1:0] i_wr_data;
    logic [NCH-1:0]    o_wr_addr_ack;
    logic [NCH-1:0]    o_wr_ack;
    logic              o_mem_rd_req;
    logic [AW-1:0]     o_mem_rd_addr;
    logic              i_mem_rd_addr_ack;
    logic              i_mem_rd_ack;
    logic [DW-1:0]     i_mem_data;
    logic              o_mem_wr_req;
    logic [AW-1:0]     o_mem_wr_addr;
    logic [DW-1:0]     o_mem_data;
    logic              i_mem_wr_addr_ack;
    logic              i_mem_wr_ack;
    logic [OW-1:0]     o_rd_outst;
    logic [1:0]        o_err;

    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
               i_mem_rd_addr_ack, i_mem_rd_ack, i_mem_data,
               i_mem_wr_addr_ack, i_mem_wr_ack,
        output o_rd_addr_ack, o_rd_ack, o_rd_data, o_wr_addr_ack, o_wr_ack,
               o_mem_rd_req, o_mem_rd_addr, o_mem_wr_req, o_mem_wr_addr,
               o_mem_data, o_rd_outst, o_err
    );

    modport master (
        output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
               i_mem_rd_addr_ack, i_mem_rd_ack, i_mem_data,
               i_mem_wr_addr_ack, i_mem_wr_ack,
        input  o_rd_addr_ack, o_rd_ack, o_rd_data, o_wr_addr_ack, o_wr_ack,
               o_mem_rd_req, o_mem_rd_addr, o_mem_wr_req, o_mem_wr_addr,
               o_mem_data, o_rd_outst, o_err
    );
endinterface

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter onto a split read/write memory port. Read and write paths are two
// identical IDLE/GRANT arbiters, each routing completions back through an in-order tag FIFO.
module mem_arbiter_nch #(
    parameter int NCH       = 4,
    parameter int AW        = 22,
    parameter int DW        = 64,
    parameter int OUTST     = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_nch_if.slave bus
);
    localparam int CW = $clog2(NCH);
    localparam int FW = $clog2(OUTST);

    typedef enum logic {IDLE, GRANT} state_t;

    // Index 0 is the read path, index 1 the write path.
    logic [NCH-1:0] req       [2];
    logic [AW-1:0]  addr      [2][NCH];
    logic [DW-1:0]  wdata     [NCH];
    logic           maddr_ack [2];
    logic           mack      [2];

    assign req[0]       = bus.i_rd_req;
    assign req[1]       = bus.i_wr_req;
    assign maddr_ack[0] = bus.i_mem_rd_addr_ack;
    assign maddr_ack[1] = bus.i_mem_wr_addr_ack;
    assign mack[0]      = bus.i_mem_rd_ack;
    assign mack[1]      = bus.i_mem_wr_ack;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign addr[0][gi] = bus.i_rd_addr[gi*AW +: AW];
            assign addr[1][gi] = bus.i_wr_addr[gi*AW +: AW];
            assign wdata[gi]   = bus.i_wr_data[gi*DW +: DW];
        end

        for (gi = 0; gi < 2; gi++) begin : g_path
            state_t         state_q;
            logic [CW-1:0]  g_q;
            logic [CW-1:0]  ptr_q;
            logic [CW-1:0]  win;
            logic           win_v;
            logic [NCH-1:0] rot;
            logic [CW-1:0]  tag_mem [OUTST];
            logic [FW-1:0]  wp_q;
            logic [FW-1:0]  rp_q;
            logic [FW:0]    cnt_q;
            logic           err_q;
            logic           grant;
            logic           accept;
            logic           pop;
            logic           can_grant;

            // Rotating the request vector by the pointer turns round-robin into a lowest-index search.
            always_comb begin
                win   = '0;
                win_v = 1'b0;
                rot   = NCH'({req[gi], req[gi]} >> ptr_q);
                for (int j = NCH - 1; j >= 0; j--) begin
                    if ((PRIO_MODE != 0) ? req[gi][j] : rot[j]) begin
                        win   = (PRIO_MODE != 0) ? CW'(j) : CW'((int'(ptr_q) + j) % NCH);
                        win_v = 1'b1;
                    end
                end
            end

            assign grant     = (state_q == GRANT);
            assign accept    = grant && req[gi][g_q] && maddr_ack[gi];
            assign pop       = mack[gi] && (cnt_q != '0);
            // A completion in the same cycle frees a slot, so a full FIFO does not stall that grant.
            assign can_grant = (cnt_q != (FW+1)'(OUTST)) || pop;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= IDLE;
                    g_q     <= '0;
                    ptr_q   <= '0;
                    wp_q    <= '0;
                    rp_q    <= '0;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end else begin
                    if (mack[gi] && (cnt_q == '0)) err_q <= 1'b1;
                    if (pop)    rp_q <= rp_q + FW'(1);
                    if (accept) wp_q <= wp_q + FW'(1);
                    cnt_q <= cnt_q + (FW+1)'(accept) - (FW+1)'(pop);
                    case (state_q)
                        IDLE: begin
                            if (win_v && can_grant) begin
                                g_q     <= win;
                                state_q <= GRANT;
                            end
                        end
                        GRANT: begin
                            if (!req[gi][g_q]) begin
                                state_q <= IDLE;
                            end else if (maddr_ack[gi]) begin
                                ptr_q   <= (g_q == CW'(NCH - 1)) ? '0 : g_q + CW'(1);
                                state_q <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (accept) tag_mem[wp_q] <= g_q;
            end

            if (gi == 0) begin : g_rd
                assign bus.o_mem_rd_req  = grant;
                assign bus.o_mem_rd_addr = grant ? addr[gi][g_q] : '0;
                assign bus.o_rd_addr_ack = accept ? (NCH'(1) << g_q) : '0;
                assign bus.o_rd_ack      = pop ? (NCH'(1) << tag_mem[rp_q]) : '0;
                assign bus.o_rd_data     = pop ? bus.i_mem_data : '0;
                assign bus.o_rd_outst    = cnt_q;
                assign bus.o_err[0]      = err_q;
            end else begin : g_wr
                assign bus.o_mem_wr_req  = grant;
                assign bus.o_mem_wr_addr = grant ? addr[gi][g_q] : '0;
                assign bus.o_mem_data    = grant ? wdata[g_q] : '0;
                assign bus.o_wr_addr_ack = accept ? (NCH'(1) << g_q) : '0;
                assign bus.o_wr_ack      = pop ? (NCH'(1) << tag_mem[rp_q]) : '0;
                assign bus.o_err[1]      = err_q;
            end
        end
    endgenerate
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Drives a round-robin and a fixed-priority arbiter with shared requestor stimulus and
// compares every output each cycle against a queue-based reference model.
module tb_mem_arbiter_nch;
    localparam int NCH = 4, AW = 22, DW = 64, OUTST = 4, OW = 3;

    logic clk, rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_nch_if #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST)) bus_rr ();
    mem_arbiter_nch_if #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST)) bus_fx ();

    mem_arbiter_nch #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST), .PRIO_MODE(0))
        u_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));
    mem_arbiter_nch #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST), .PRIO_MODE(1))
        u_fx (.clk(clk), .rst(rst), .bus(bus_fx.slave));

    // Shared requestor stimulus, per-DUT memory responses (index 0 = rr, 1 = fx).
    logic [NCH-1:0]    rd_req, wr_req;
    logic [NCH*AW-1:0] rd_addr_f, wr_addr_f;
    logic [NCH*DW-1:0] wr_data_f;
    logic [DW-1:0]     mem_data;
    logic              m_raack [2], m_rack [2], m_waack [2], m_wack [2];

    assign bus_rr.i_rd_req = rd_req;      assign bus_fx.i_rd_req = rd_req;
    assign bus_rr.i_rd_addr = rd_addr_f;  assign bus_fx.i_rd_addr = rd_addr_f;
    assign bus_rr.i_wr_req = wr_req;      assign bus_fx.i_wr_req = wr_req;
    assign bus_rr.i_wr_addr = wr_addr_f;  assign bus_fx.i_wr_addr = wr_addr_f;
    assign bus_rr.i_wr_data = wr_data_f;  assign bus_fx.i_wr_data = wr_data_f;
    assign bus_rr.i_mem_data = mem_data;  assign bus_fx.i_mem_data = mem_data;
    assign bus_rr.i_mem_rd_addr_ack = m_raack[0]; assign bus_fx.i_mem_rd_addr_ack = m_raack[1];
    assign bus_rr.i_mem_rd_ack      = m_rack[0];  assign bus_fx.i_mem_rd_ack      = m_rack[1];
    assign bus_rr.i_mem_wr_addr_ack = m_waack[0]; assign bus_fx.i_mem_wr_addr_ack = m_waack[1];
    assign bus_rr.i_mem_wr_ack      = m_wack[0];  assign bus_fx.i_mem_wr_ack      = m_wack[1];

    logic           o_mreq  [2][2];
    logic [AW-1:0]  o_maddr [2][2];
    logic [NCH-1:0] o_aack  [2][2];
    logic [NCH-1:0] o_ack   [2][2];
    logic [DW-1:0]  o_rdata [2];
    logic [DW-1:0]  o_mdata [2];
    logic [OW-1:0]  o_outst [2];
    logic [1:0]     o_err   [2];

    assign o_mreq[0][0] = bus_rr.o_mem_rd_req;   assign o_mreq[1][0] = bus_fx.o_mem_rd_req;
    assign o_mreq[0][1] = bus_rr.o_mem_wr_req;   assign o_mreq[1][1] = bus_fx.o_mem_wr_req;
    assign o_maddr[0][0] = bus_rr.o_mem_rd_addr; assign o_maddr[1][0] = bus_fx.o_mem_rd_addr;
    assign o_maddr[0][1] = bus_rr.o_mem_wr_addr; assign o_maddr[1][1] = bus_fx.o_mem_wr_addr;
    assign o_aack[0][0] = bus_rr.o_rd_addr_ack;  assign o_aack[1][0] = bus_fx.o_rd_addr_ack;
    assign o_aack[0][1] = bus_rr.o_wr_addr_ack;  assign o_aack[1][1] = bus_fx.o_wr_addr_ack;
    assign o_ack[0][0] = bus_rr.o_rd_ack;        assign o_ack[1][0] = bus_fx.o_rd_ack;
    assign o_ack[0][1] = bus_rr.o_wr_ack;        assign o_ack[1][1] = bus_fx.o_wr_ack;
    assign o_rdata[0] = bus_rr.o_rd_data;        assign o_rdata[1] = bus_fx.o_rd_data;
    assign o_mdata[0] = bus_rr.o_mem_data;       assign o_mdata[1] = bus_fx.o_mem_data;
    assign o_outst[0] = bus_rr.o_rd_outst;       assign o_outst[1] = bus_fx.o_rd_outst;
    assign o_err[0] = bus_rr.o_err;              assign o_err[1] = bus_fx.o_err;

    // Reference model: granted channel (-1 = none), RR pointer, and in-order tag list per DUT/path.
    int m_g [2][2], m_ptr [2][2], m_cnt [2][2];
    int m_tags [2][2][OUTST];
    bit m_err [2][2];
    int gq_rr[$], gq_fx[$];
    int n_cmp = 0, n_bad = 0;
    string dn[2] = '{"rr", "fx"};
    string pn[2] = '{"rd", "wr"};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] req_of(input int p);
        return (p == 1) ? wr_req : rd_req;
    endfunction
    function automatic logic [AW-1:0] addr_of(input int p, input int k);
        return (p == 1) ? wr_addr_f[k*AW +: AW] : rd_addr_f[k*AW +: AW];
    endfunction
    function automatic logic aack_of(input int d, input int p);
        return (p == 1) ? m_waack[d] : m_raack[d];
    endfunction
    function automatic logic mack_of(input int d, input int p);
        return (p == 1) ? m_wack[d] : m_rack[d];
    endfunction
    function automatic int oh_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Fixed priority: lowest index. Round-robin: first requester at or after the pointer.
    function automatic int winner(input int d, input logic [NCH-1:0] rq, input int ptr);
        for (int i = 0; i < NCH; i++) begin
            int k;
            k = (d == 1) ? i : (ptr + i) % NCH;
            if (rq[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                m_g[d][p] = -1; m_ptr[d][p] = 0; m_cnt[d][p] = 0; m_err[d][p] = 1'b0;
            end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic [NCH-1:0] rq;
                int g;
                bit busy, acc, pop;
                rq   = req_of(p);
                g    = m_g[d][p];
                busy = (g >= 0);
                acc  = busy ? (rq[g] && aack_of(d, p)) : 1'b0;
                pop  = mack_of(d, p) && (m_cnt[d][p] > 0);
                chk($sformatf("%s.%s.mem_req", dn[d], pn[p]), 64'(o_mreq[d][p]), 64'(busy));
                chk($sformatf("%s.%s.mem_addr", dn[d], pn[p]), 64'(o_maddr[d][p]),
                    busy ? 64'(addr_of(p, g)) : 64'd0);
                chk($sformatf("%s.%s.addr_ack", dn[d], pn[p]), 64'(o_aack[d][p]),
                    acc ? (64'd1 << g) : 64'd0);
                chk($sformatf("%s.%s.ack", dn[d], pn[p]), 64'(o_ack[d][p]),
                    pop ? (64'd1 << m_tags[d][p][0]) : 64'd0);
                if (p == 0) begin
                    chk($sformatf("%s.rd_data", dn[d]), o_rdata[d], pop ? mem_data : 64'd0);
                    chk($sformatf("%s.rd_outst", dn[d]), 64'(o_outst[d]), 64'(m_cnt[d][0]));
                end else begin
                    chk($sformatf("%s.mem_data", dn[d]), o_mdata[d],
                        busy ? wr_data_f[g*DW +: DW] : 64'd0);
                end
            end
            chk($sformatf("%s.err", dn[d]), 64'(o_err[d]), 64'({m_err[d][1], m_err[d][0]}));
            if (o_aack[d][0] != '0) begin
                if (d == 0) gq_rr.push_back(oh_idx(o_aack[d][0]));
                else        gq_fx.push_back(oh_idx(o_aack[d][0]));
            end
        end
    endtask

    task automatic advance_model();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic [NCH-1:0] rq;
                int g;
                bit pop, can;
                rq  = req_of(p);
                g   = m_g[d][p];
                pop = mack_of(d, p) && (m_cnt[d][p] > 0);
                can = (m_cnt[d][p] < OUTST) || pop;
                if (mack_of(d, p) && m_cnt[d][p] == 0) m_err[d][p] = 1'b1;
                if (pop) begin
                    $display("txn %s %s complete ch%0d", dn[d], pn[p], m_tags[d][p][0]);
                    for (int i = 0; i < OUTST - 1; i++) m_tags[d][p][i] = m_tags[d][p][i+1];
                    m_cnt[d][p]--;
                end
                if (g >= 0) begin
                    if (!rq[g]) begin
                        m_g[d][p] = -1;
                    end else if (aack_of(d, p)) begin
                        $display("txn %s %s issue ch%0d addr=%h", dn[d], pn[p], g, addr_of(p, g));
                        m_tags[d][p][m_cnt[d][p]] = g;
                        m_cnt[d][p]++;
                        m_ptr[d][p] = (g + 1) % NCH;
                        m_g[d][p]   = -1;
                    end
                end else if (rq != '0 && can) begin
                    m_g[d][p] = winner(d, rq, m_ptr[d][p]);
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        advance_model();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rd_req = '0; wr_req = '0; mem_data = '0;
        for (int d = 0; d < 2; d++) begin
            m_raack[d] = 1'b0; m_rack[d] = 1'b0; m_waack[d] = 1'b0; m_wack[d] = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        set_idle();
        for (int c = 0; c < n; c++) begin
            for (int d = 0; d < 2; d++) begin
                m_rack[d] = (m_cnt[d][0] > 0);
                m_wack[d] = (m_cnt[d][1] > 0);
            end
            cycle();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_addr_f = '0; wr_addr_f = '0; wr_data_f = '0;
        for (int k = 0; k < NCH; k++) begin
            rd_addr_f[k*AW +: AW] = AW'(32'h100 * (k + 1));
            wr_addr_f[k*AW +: AW] = AW'(32'h2000 + k);
            wr_data_f[k*DW +: DW] = {$urandom, $urandom};
        end
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;

        // Round-robin sweep with all four channels requesting and immediate acceptance.
        rd_req = 4'b1111;
        gq_rr.delete(); gq_fx.delete();
        for (int c = 0; c < 12; c++) begin
            m_raack[0] = 1'b1; m_raack[1] = 1'b1;
            for (int d = 0; d < 2; d++) m_rack[d] = (m_cnt[d][0] > 0);
            cycle();
        end
        chk("t1.rr_grant_count", 64'(gq_rr.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < gq_rr.size(); k++)
            chk($sformatf("t1.rr_grant%0d", k), 64'(gq_rr[k]), 64'(k % NCH));
        drain(8);

        // Fixed priority keeps channel 1 ahead of channel 2.
        rd_req = 4'b0110;
        gq_rr.delete(); gq_fx.delete();
        for (int c = 0; c < 12; c++) begin
            m_raack[0] = 1'b1; m_raack[1] = 1'b1;
            for (int d = 0; d < 2; d++) m_rack[d] = (m_cnt[d][0] > 0);
            cycle();
        end
        chk("t2.fx_grant_count", 64'(gq_fx.size() >= 5), 64'd1);
        foreach (gq_fx[k]) chk($sformatf("t2.fx_grant%0d", k), 64'(gq_fx[k]), 64'd1);
        drain(8);

        // Outstanding limit: completions withheld until the FIFO fills.
        rd_req = 4'b1111;
        m_raack[0] = 1'b1; m_raack[1] = 1'b1;
        repeat (11) cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t3.%s.outst_full", dn[d]), 64'(o_outst[d]), 64'd4);
            chk($sformatf("t3.%s.req_blocked", dn[d]), 64'(o_mreq[d][0]), 64'd0);
        end
        m_rack[0] = 1'b1; m_rack[1] = 1'b1;
        cycle();
        m_rack[0] = 1'b0; m_rack[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t3.%s.req_resumed", dn[d]), 64'(o_mreq[d][0]), 64'd1);
            chk($sformatf("t3.%s.outst_after_pop", dn[d]), 64'(o_outst[d]), 64'd3);
        end
        drain(8);

        // Independent read and write paths issued in the same cycle.
        rd_addr_f[2*AW +: AW] = 22'h00123;
        wr_addr_f[1*AW +: AW] = 22'h3FFFFF;
        rd_req = 4'b0100; wr_req = 4'b0010;
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t4.%s.rd_req", dn[d]), 64'(o_mreq[d][0]), 64'd1);
            chk($sformatf("t4.%s.rd_addr", dn[d]), 64'(o_maddr[d][0]), 64'h00123);
            chk($sformatf("t4.%s.wr_req", dn[d]), 64'(o_mreq[d][1]), 64'd1);
            chk($sformatf("t4.%s.wr_addr", dn[d]), 64'(o_maddr[d][1]), 64'h3FFFFF);
        end
        for (int d = 0; d < 2; d++) begin m_raack[d] = 1'b1; m_waack[d] = 1'b1; end
        cycle();
        set_idle();
        cycle();
        mem_data = 64'hDEAD_BEEF;
        for (int d = 0; d < 2; d++) begin m_rack[d] = 1'b1; m_wack[d] = 1'b1; end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t4.%s.rd_ack", dn[d]), 64'(o_ack[d][0]), 64'b0100);
            chk($sformatf("t4.%s.rd_data", dn[d]), o_rdata[d], 64'hDEAD_BEEF);
            chk($sformatf("t4.%s.wr_ack", dn[d]), 64'(o_ack[d][1]), 64'b0010);
        end
        cycle();
        set_idle();

        // Read completion with nothing outstanding.
        m_rack[0] = 1'b1; m_rack[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("t5.%s.no_ack", dn[d]), 64'(o_ack[d][0]), 64'd0);
        cycle();
        set_idle();
        for (int d = 0; d < 2; d++) chk($sformatf("t5.%s.err_set", dn[d]), 64'(o_err[d]), 64'b01);
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) chk($sformatf("t5.%s.err_sticky", dn[d]), 64'(o_err[d]), 64'b01);

        // Random traffic: requests come and go (including aborts), memory responds legally.
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if (!rd_req[k]) begin
                    rd_addr_f[k*AW +: AW] = AW'($urandom);
                    rd_req[k] = ($urandom_range(0, 2) == 0);
                end else begin
                    rd_req[k] = ($urandom_range(0, 7) != 0);
                end
                if (!wr_req[k]) begin
                    wr_addr_f[k*AW +: AW] = AW'($urandom);
                    wr_data_f[k*DW +: DW] = {$urandom, $urandom};
                    wr_req[k] = ($urandom_range(0, 2) == 0);
                end else begin
                    wr_req[k] = ($urandom_range(0, 7) != 0);
                end
            end
            mem_data = {$urandom, $urandom};
            for (int d = 0; d < 2; d++) begin
                m_raack[d] = 1'($urandom_range(0, 1));
                m_waack[d] = 1'($urandom_range(0, 1));
                m_rack[d]  = (m_cnt[d][0] > 0) && ($urandom_range(0, 2) == 0);
                m_wack[d]  = (m_cnt[d][1] > 0) && ($urandom_range(0, 2) == 0);
            end
            cycle();
        end
        drain(8);

        // Asynchronous reset with two reads outstanding and a third grant pending.
        rd_req = 4'b0011;
        m_raack[0] = 1'b1; m_raack[1] = 1'b1;
        repeat (4) cycle();
        rd_req = 4'b0100;
        m_raack[0] = 1'b0; m_raack[1] = 1'b0;
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6.%s.outst_before", dn[d]), 64'(o_outst[d]), 64'd2);
            chk($sformatf("t6.%s.grant_before", dn[d]), 64'(o_mreq[d][0]), 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6.%s.rst_req", dn[d]), 64'(o_mreq[d][0]), 64'd0);
            chk($sformatf("t6.%s.rst_addr", dn[d]), 64'(o_maddr[d][0]), 64'd0);
            chk($sformatf("t6.%s.rst_outst", dn[d]), 64'(o_outst[d]), 64'd0);
            chk($sformatf("t6.%s.rst_err", dn[d]), 64'(o_err[d]), 64'd0);
        end
        set_idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin m_rack[d] = 1'b1; m_wack[d] = 1'b1; end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6.%s.late_rd_ack", dn[d]), 64'(o_ack[d][0]), 64'd0);
            chk($sformatf("t6.%s.late_wr_ack", dn[d]), 64'(o_ack[d][1]), 64'd0);
        end
        cycle();
        set_idle();
        for (int d = 0; d < 2; d++) chk($sformatf("t6.%s.late_err", dn[d]), 64'(o_err[d]), 64'b11);
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
